// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aud_pkg
// Brief    : Shared audio-block types and default widths.
// Revision : 1.0
// ============================================================================
package aud_pkg;

    localparam int AUD_ADDR_W   = 20;
    localparam int AUD_SAMPLE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RECV  = 3'd2,
        ST_WRITE = 3'd3,
        ST_PAUSE = 3'd4,
        ST_FULL  = 3'd5
    } aud_state_e;

endpackage
`default_nettype wire

// File: rtl/aud_i2s_deser.sv
`default_nettype none
// ============================================================================
// Module   : aud_i2s_deser
// Brief    : Left-channel I2S deserialiser: LRC edge detect, MSB-first shift,
//            one-cycle valid pulse on the cycle after the last bit.
// Revision : 1.0
// ============================================================================
module aud_i2s_deser
    import aud_pkg::*;
#(
    parameter int SAMPLE_W = AUD_SAMPLE_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_lrc,
    input  logic                i_data,
    input  logic                i_arm,
    input  logic                i_abort,
    output logic                o_edge,
    output logic                o_last,
    output logic                o_valid,
    output logic [SAMPLE_W-1:0] o_sample
);

    localparam int                CNT_W      = $clog2(SAMPLE_W);
    localparam logic [CNT_W-1:0]  c_last_bit = CNT_W'(SAMPLE_W - 1);

    logic                r_lrc;
    logic                r_busy;
    logic [CNT_W-1:0]    r_cnt;
    logic [SAMPLE_W-1:0] r_shift;
    logic                r_valid;

    assign o_edge   = r_lrc & ~i_lrc;
    assign o_last   = r_busy & (r_cnt == c_last_bit);
    assign o_valid  = r_valid;
    assign o_sample = r_shift;

    // Capture begins the cycle after the edge, giving the I2S one-BCLK delay.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lrc   <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
        end else begin
            r_lrc   <= i_lrc;
            r_valid <= 1'b0;
            if (r_busy) begin
                r_shift <= {r_shift[SAMPLE_W-2:0], i_data};
                r_cnt   <= r_cnt + 1'b1;
                if (i_abort) begin
                    r_busy <= 1'b0;
                end else if (r_cnt == c_last_bit) begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                end
            end else if (o_edge && i_arm) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aud_recorder.sv
`default_nettype none
// ============================================================================
// Module   : aud_recorder
// Brief    : Records left-channel I2S samples into SRAM with start/pause/stop
//            control and saturating full detection.
// Revision : 1.0
// ============================================================================
module aud_recorder
    import aud_pkg::*;
#(
    parameter int ADDR_W   = AUD_ADDR_W,
    parameter int SAMPLE_W = AUD_SAMPLE_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_lrc,
    input  logic                i_data,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    output logic [ADDR_W-1:0]   o_address,
    output logic [SAMPLE_W-1:0] o_data,
    output logic                o_wr,
    output logic [ADDR_W-1:0]   o_length,
    output logic                o_full,
    output logic [2:0]          o_state
);

    localparam logic [ADDR_W-1:0] c_addr_max = '1;

    aud_state_e          r_state, w_state_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [ADDR_W-1:0]   r_len, w_len_next;
    logic [SAMPLE_W-1:0] r_data;
    logic                w_edge, w_last, w_valid, w_arm, w_abort;
    logic [SAMPLE_W-1:0] w_sample;

    // A pause or stop in WAIT/RECV must keep the deserialiser from delivering a sample.
    assign w_arm   = (r_state == ST_WAIT) & ~i_stop & ~i_pause;
    assign w_abort = (r_state == ST_RECV) & (i_stop | i_pause);

    aud_i2s_deser #(
        .SAMPLE_W (SAMPLE_W)
    ) u_deser (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_lrc    (i_lrc),
        .i_data   (i_data),
        .i_arm    (w_arm),
        .i_abort  (w_abort),
        .o_edge   (w_edge),
        .o_last   (w_last),
        .o_valid  (w_valid),
        .o_sample (w_sample)
    );

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_len_next   = r_len;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_WAIT;
                    w_addr_next  = '0;
                    w_len_next   = '0;
                end
            end
            ST_WAIT: begin
                if (i_stop)       w_state_next = ST_IDLE;
                else if (i_pause) w_state_next = ST_PAUSE;
                else if (w_edge)  w_state_next = ST_RECV;
            end
            ST_RECV: begin
                if (i_stop)       w_state_next = ST_IDLE;
                else if (i_pause) w_state_next = ST_PAUSE;
                else if (w_last)  w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                // The write always commits; commands only choose where to go next.
                if (r_addr == c_addr_max) begin
                    w_state_next = ST_FULL;
                    if (r_len != c_addr_max) w_len_next = r_len + 1'b1;
                end else begin
                    w_state_next = ST_WAIT;
                    w_addr_next  = r_addr + 1'b1;
                    w_len_next   = r_len + 1'b1;
                end
                if (i_stop)       w_state_next = ST_IDLE;
                else if (i_pause) w_state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (i_stop)       w_state_next = ST_IDLE;
                else if (i_start) w_state_next = ST_WAIT;
            end
            ST_FULL: begin
                if (i_stop) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_len   <= w_len_next;
            if (r_state == ST_WRITE) r_data <= w_sample;
        end
    end

    // The shift register is live only during WRITE; r_data holds it afterwards.
    assign o_wr      = (r_state == ST_WRITE) & w_valid & ~i_rst;
    assign o_data    = (r_state == ST_WRITE) ? w_sample : r_data;
    assign o_address = r_addr;
    assign o_length  = r_len;
    assign o_full    = (r_state == ST_FULL);
    assign o_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_aud_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_aud_recorder
// Brief    : Directed self-checking bench for aud_recorder (ADDR_W = 4).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_aud_recorder;

    localparam int ADDR_W   = 4;
    localparam int SAMPLE_W = 16;

    logic                clk = 1'b0;
    logic                i_rst, i_lrc, i_data, i_start, i_pause, i_stop;
    logic [ADDR_W-1:0]   o_address, o_length;
    logic [SAMPLE_W-1:0] o_data;
    logic                o_wr, o_full;
    logic [2:0]          o_state;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          wr_addr[$];
    logic [15:0] wr_data[$];
    int          len_after[$];
    logic        prev_wr = 1'b0;
    logic [15:0] exp_words[3];

    always #5 clk = ~clk;

    aud_recorder #(
        .ADDR_W   (ADDR_W),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_lrc     (i_lrc),
        .i_data    (i_data),
        .i_start   (i_start),
        .i_pause   (i_pause),
        .i_stop    (i_stop),
        .o_address (o_address),
        .o_data    (o_data),
        .o_wr      (o_wr),
        .o_length  (o_length),
        .o_full    (o_full),
        .o_state   (o_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Logs write strobes mid-cycle, then advances to just after the next edge.
    task automatic step();
        #1;
        if (prev_wr) len_after.push_back(int'(o_length));
        prev_wr = o_wr;
        if (o_wr) begin
            wr_addr.push_back(int'(o_address));
            wr_data.push_back(o_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        len_after.delete();
    endtask

    task automatic pulse(input logic start, input logic pause, input logic stop);
        i_start = start;
        i_pause = pause;
        i_stop  = stop;
        step();
        i_start = 1'b0;
        i_pause = 1'b0;
        i_stop  = 1'b0;
    endtask

    // One LRC period: 25 cycles left (lrc=0), 25 right; bits follow the one-cycle delay slot.
    task automatic frame(input logic [15:0] l, input logic [15:0] r,
                         input int pause_c, input int stop_c, input int rst_c);
        for (int c = 0; c < 50; c++) begin
            i_lrc = (c >= 25);
            if (c >= 1 && c <= 16)       i_data = l[16-c];
            else if (c >= 26 && c <= 41) i_data = r[41-c];
            else                         i_data = 1'b0;
            i_pause = (c == pause_c);
            i_stop  = (c == stop_c);
            i_rst   = (c == rst_c);
            step();
        end
        i_pause = 1'b0;
        i_stop  = 1'b0;
        i_rst   = 1'b0;
        i_data  = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_lrc = 1'b1; i_data = 1'b0;
        i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        @(posedge clk); #1;
        step();
        step();
        i_rst = 1'b0;
        step();
        check("reset_state",   32'(o_state),   32'd0);
        check("reset_address", 32'(o_address), 32'd0);
        check("reset_data",    32'(o_data),    32'd0);
        check("reset_length",  32'(o_length),  32'd0);
        check("reset_wr",      32'(o_wr),      32'd0);
        check("reset_full",    32'(o_full),    32'd0);

        // Basic capture
        clear_log();
        pulse(1'b1, 1'b0, 1'b0);
        check("start_to_wait", 32'(o_state), 32'd1);
        frame(16'hA5C3, 16'h5A5A, -1, -1, -1);
        check("basic_wr_count",  32'(wr_addr.size()), 32'd1);
        check("basic_addr",      32'(wr_addr[0]),     32'd0);
        check("basic_data",      32'(wr_data[0]),     32'hA5C3);
        check("basic_len_after", 32'(len_after[0]),   32'd1);

        // Continuous capture after restart from IDLE
        pulse(1'b0, 1'b0, 1'b1);
        check("stop_idle",       32'(o_state),  32'd0);
        check("stop_len_held",   32'(o_length), 32'd1);
        clear_log();
        pulse(1'b1, 1'b0, 1'b0);
        check("restart_addr",    32'(o_address), 32'd0);
        check("restart_len",     32'(o_length),  32'd0);
        exp_words[0] = 16'h1234; exp_words[1] = 16'h8000; exp_words[2] = 16'hFFFF;
        frame(exp_words[0], 16'hDEAD, -1, -1, -1);
        frame(exp_words[1], 16'hBEEF, -1, -1, -1);
        frame(exp_words[2], 16'h0F0F, -1, -1, -1);
        check("cont_wr_count", 32'(wr_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("cont_addr", 32'(wr_addr[i]), 32'(i));
            check("cont_data", 32'(wr_data[i]), 32'(exp_words[i]));
        end
        check("cont_len_after", 32'(len_after[2]), 32'd3);

        // Pause at bit 7 of word 2, then resume
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        clear_log();
        frame(16'h1111, 16'h2222, -1, -1, -1);
        frame(16'h4444, 16'h8888, -1, -1, -1);
        frame(16'h6666, 16'h7777, 9, -1, -1);
        check("pause_wr_count", 32'(wr_addr.size()), 32'd2);
        check("pause_state",    32'(o_state),        32'd4);
        check("pause_addr",     32'(o_address),      32'd2);
        check("pause_len",      32'(o_length),       32'd2);
        pulse(1'b1, 1'b0, 1'b0);
        check("resume_state",   32'(o_state),   32'd1);
        check("resume_addr",    32'(o_address), 32'd2);
        frame(16'h3C3C, 16'hC3C3, -1, -1, -1);
        check("resume_wr_count", 32'(wr_addr.size()), 32'd3);
        check("resume_wr_addr",  32'(wr_addr[2]),     32'd2);
        check("resume_wr_data",  32'(wr_data[2]),     32'h3C3C);
        check("resume_len",      32'(o_length),       32'd3);

        // Coincident stop and pause during RECV
        clear_log();
        frame(16'h5555, 16'hAAAA, 5, 5, -1);
        check("coinc_state",    32'(o_state),        32'd0);
        check("coinc_wr_count", 32'(wr_addr.size()), 32'd0);
        check("coinc_len",      32'(o_length),       32'd3);
        check("coinc_addr",     32'(o_address),      32'd3);

        // Fill all 16 locations
        pulse(1'b1, 1'b0, 1'b0);
        clear_log();
        for (int i = 0; i < 16; i++) frame(16'h1000 + 16'(i), 16'hEEEE, -1, -1, -1);
        check("full_wr_count", 32'(wr_addr.size()), 32'd16);
        check("full_last_addr", 32'(wr_addr[15]),  32'd15);
        check("full_last_data", 32'(wr_data[15]),  32'h100F);
        check("full_flag",      32'(o_full),       32'd1);
        check("full_state",     32'(o_state),      32'd5);
        check("full_addr",      32'(o_address),    32'd15);
        check("full_len",       32'(o_length),     32'd15);
        pulse(1'b1, 1'b0, 1'b0);
        check("full_start_ignored", 32'(o_state), 32'd5);
        pulse(1'b0, 1'b1, 1'b0);
        check("full_pause_ignored", 32'(o_state), 32'd5);
        frame(16'h7777, 16'h9999, -1, -1, -1);
        check("full_no_write", 32'(wr_addr.size()), 32'd16);
        pulse(1'b0, 1'b0, 1'b1);
        check("full_stop_state", 32'(o_state),  32'd0);
        check("full_stop_len",   32'(o_length), 32'd15);
        check("full_stop_flag",  32'(o_full),   32'd0);

        // Reset during RECV, then reset during WRITE
        pulse(1'b1, 1'b0, 1'b0);
        clear_log();
        frame(16'hBEEF, 16'h0000, -1, -1, -1);
        check("prerst_data", 32'(o_data), 32'hBEEF);
        frame(16'h1357, 16'h0000, -1, -1, 8);
        check("rst_recv_state", 32'(o_state),        32'd0);
        check("rst_recv_addr",  32'(o_address),      32'd0);
        check("rst_recv_len",   32'(o_length),       32'd0);
        check("rst_recv_data",  32'(o_data),         32'd0);
        check("rst_recv_full",  32'(o_full),         32'd0);
        check("rst_recv_wr",    32'(wr_addr.size()), 32'd1);
        pulse(1'b1, 1'b0, 1'b0);
        frame(16'h2468, 16'h0000, -1, -1, 17);
        check("rst_write_no_wr", 32'(wr_addr.size()), 32'd1);
        check("rst_write_state", 32'(o_state),        32'd0);
        check("rst_write_len",   32'(o_length),       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aud_recorder.md
AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 SHALL have parameter SAMPLE_W, default 16, bits per audio sample.
REQ-003 SHALL have port i_clk, input, 1, the AUD_BCLK domain. It is the single clock, and every flop is updated on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset. It is synchronous and active-high.
REQ-005 SHALL have port i_lrc, input, 1, AUD_ADCLRCK: low selects the left channel, high selects the right channel.
REQ-006 SHALL have port i_data, input, 1, AUD_ADCDAT serial bit, MSB first.
REQ-007 SHALL have ports i_start, i_pause, i_stop, input, 1 each, single-cycle command pulses.
REQ-008 SHALL have port o_address, output, ADDR_W, SRAM word address of the current write.
REQ-009 SHALL have port o_data, output, SAMPLE_W, sample being written.
REQ-010 SHALL have port o_wr, output, 1, one-cycle SRAM write strobe (active-high).
REQ-011 SHALL have port o_length, output, ADDR_W, count of samples committed since the last start-from-IDLE.
REQ-012 SHALL have port o_full, output, 1, high while in FULL.
REQ-013 SHALL have port o_state, output, 3, encoded FSM state for debug and top-level muxing.

Function
REQ-014 SHALL implement states IDLE, WAIT, RECV, WRITE, PAUSE and FULL.
REQ-015 SHALL register i_lrc every cycle. A left-channel edge is the cycle where registered lrc = 1 and i_lrc = 0. Right-channel data is ignored.
REQ-016 SHALL, in IDLE on i_start, clear o_address and o_length to 0 and go to WAIT.
REQ-017 SHALL, in WAIT, go to RECV on the left-channel edge (edge cycle k).
REQ-018 SHALL, in RECV, shift i_data into the sample register on cycles k+1..k+16 (I2S one-BCLK delay), with the MSB first.
REQ-019 SHALL, on cycle k+17 (WRITE), drive o_data = sample, o_wr = 1 and o_address = current address for exactly one cycle.
REQ-020 SHALL, on the cycle after WRITE, increment o_address and o_length by 1 and return to WAIT.
REQ-021 SHALL, when WRITE commits at address 2^ADDR_W-1, go to FULL instead of wrapping. o_address holds 2^ADDR_W-1 and o_length saturates at 2^ADDR_W-1.
REQ-022 SHALL, in FULL, ignore i_start and i_pause; only i_stop returns the block to IDLE.
REQ-023 SHALL, on i_pause in WAIT or RECV, discard any partial sample and enter PAUSE with address and length held.
REQ-024 SHALL, on i_pause during WRITE, complete that write first and then enter PAUSE.
REQ-025 SHALL, on i_start in PAUSE, go to WAIT without clearing address or length.
REQ-026 SHALL, on i_stop in any non-IDLE state, go to IDLE next cycle with o_length held. A write in progress is completed first.
REQ-027 SHALL apply command priority stop > pause > start when pulses coincide. Commands that are invalid in the current state are ignored.
REQ-028 SHALL hold o_wr = 0 in every state except WRITE, and keep o_data stable outside WRITE.
REQ-029 SHALL require each i_lrc half-period to be at least 18 BCLK cycles. Shorter periods are out of contract.

Reset
REQ-030 SHALL, on i_rst = 1 at a clock edge, enter IDLE and zero o_address, o_data, o_length, o_wr, o_full, the shift register and the registered lrc.
REQ-031 SHALL, on reset mid-RECV or mid-WRITE, abort with no o_wr pulse on the reset cycle.

Structure
REQ-032 SHALL place the state enum (3-bit), SAMPLE_W and ADDR_W defaults in shared package aud_pkg, alongside the other audio blocks.
REQ-033 SHALL use one sub-module, aud_i2s_deser: edge detect, 16-bit shift and a sample_valid pulse at k+17. The FSM and address logic stay in aud_recorder.

Verification
REQ-034 SHALL test basic capture: reset, i_start, LRC half-period 25 BCLK, left word 16'hA5C3 -> o_wr once, o_data = A5C3, o_address = 0, and one cycle later o_length = 1.
REQ-035 SHALL test continuous capture: 3 left words 1234, 8000, FFFF -> writes at addresses 0, 1, 2 with those values; the right words never appear on o_data.
REQ-036 SHALL test pause and resume: i_pause at bit 7 of word 2 -> no write for word 2. Then i_start -> the next word is written at address 2, not 0.
REQ-037 SHALL test full and stop: ADDR_W = 4, record 16 words -> o_full = 1 after write at 15, i_start ignored. Then i_stop -> IDLE with o_length = 15.
REQ-038 SHALL test coincident commands and reset: i_stop with i_pause in RECV -> IDLE. i_rst during RECV -> all outputs 0 and no o_wr.
